// File: rtl/saida_pkg.sv
// Shared definitions for the OUT-instruction display stage.
//   LARGURA     : width of the captured value and number of conversion shifts
//   DIGITOS     : number of BCD digits produced
//   BCD_W       : width of the BCD accumulator (4 bits per digit)
//   CONT_W      : width of the shift counter
//   LIMITE      : largest value shown numerically
//   COD_APAGADO : digit code for a blank display
//   COD_ERRO    : digit code for "E" (overflow)
//   estado_t    : conversion FSM state encoding
package saida_pkg;

   localparam int LARGURA = 32;
   localparam int DIGITOS = 5;
   localparam int BCD_W   = 4 * DIGITOS;
   localparam int CONT_W  = $clog2(LARGURA);

   localparam logic [LARGURA-1:0] LIMITE      = LARGURA'(99999);
   localparam logic [3:0]         COD_APAGADO = 4'd15;
   localparam logic [3:0]         COD_ERRO    = 4'd14;

   typedef enum logic [1:0] {
      OCIOSO   = 2'd0,
      CONVERTE = 2'd1,
      CONCLUI  = 2'd2
   } estado_t;

endpackage

// File: rtl/ajuste_bcd.sv
// Double-dabble correction for one BCD nibble: adds 3 when the nibble is 5
// or more, so the following left shift carries into the next decimal digit.
//   entrada : nibble before correction
//   saida   : corrected nibble
module ajuste_bcd (
   input  logic [3:0] entrada,
   output logic [3:0] saida
);

   assign saida = (entrada >= 4'd5) ? (entrada + 4'd3) : entrada;

endmodule

// File: rtl/conversor_bcd_saida.sv
// Sequential output stage for the OUT instruction. Captures a 32-bit value on
// an OUT strobe, converts it to five BCD digits by shift-add-3 (one bit per
// clock) and updates all digits at once when the conversion ends.
//   clock       : system clock, rising edge
//   reset       : asynchronous, active-high reset
//   entrada     : value from the OUT datapath
//   controleOUT : OUT strobe, a capture request on every rising edge it is high
//   n1..n5      : units .. ten-thousands digits, registered
//   ocupado     : high while a conversion is in progress
//   pronto      : one-cycle pulse when n1..n5 update
//
// state    | meaning
// ---------+----------------------------------------------------------
// OCIOSO   | idle, waiting for a strobe
// CONVERTE | one correction+shift per clock, LARGURA clocks in total
// CONCLUI  | accumulator holds the result; digits load on leaving edge
module conversor_bcd_saida
   import saida_pkg::*;
(
   input  logic               clock,
   input  logic               reset,
   input  logic [LARGURA-1:0] entrada,
   input  logic               controleOUT,
   output logic [3:0]         n1,
   output logic [3:0]         n2,
   output logic [3:0]         n3,
   output logic [3:0]         n4,
   output logic [3:0]         n5,
   output logic               ocupado,
   output logic               pronto
);

   localparam logic [CONT_W-1:0] CONT_FIM = CONT_W'(LARGURA - 1);

   estado_t estado, estado_prox;

   logic [LARGURA-1:0]       desloc;
   logic [LARGURA-1:0]       espera;
   logic                     pendente;
   logic [BCD_W-1:0]         bcd;
   logic [BCD_W-1:0]         bcd_aj;
   logic [BCD_W+LARGURA-1:0] conc_desl;
   logic                     ovf;
   logic [CONT_W-1:0]        cont;

   logic                     captura;
   logic [LARGURA-1:0]       valor_captura;

   for (genvar i = 0; i < DIGITOS; i++) begin : g_ajuste
      ajuste_bcd u_ajuste (
         .entrada (bcd[4*i +: 4]),
         .saida   (bcd_aj[4*i +: 4])
      );
   end

   // Carries out of the top digit fall off the shift; they can only occur
   // for values above LIMITE, which display the error code anyway.
   assign conc_desl = {bcd_aj, desloc} << 1;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         estado <= OCIOSO;
      end else begin
         estado <= estado_prox;
      end
   end

   always_comb begin
      estado_prox   = estado;
      captura       = 1'b0;
      valor_captura = entrada;
      ocupado       = 1'b0;
      case (estado)
         OCIOSO: begin
            if (controleOUT) begin
               captura     = 1'b1;
               estado_prox = CONVERTE;
            end
         end
         CONVERTE: begin
            ocupado = 1'b1;
            if (cont == CONT_FIM) begin
               estado_prox = CONCLUI;
            end
         end
         CONCLUI: begin
            // A strobe on this very edge is newer than anything held.
            if (controleOUT) begin
               captura     = 1'b1;
               estado_prox = CONVERTE;
            end else if (pendente) begin
               captura       = 1'b1;
               valor_captura = espera;
               estado_prox   = CONVERTE;
            end else begin
               estado_prox = OCIOSO;
            end
         end
         default: begin
            estado_prox = OCIOSO;
         end
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         desloc   <= '0;
         espera   <= '0;
         pendente <= 1'b0;
         bcd      <= '0;
         ovf      <= 1'b0;
         cont     <= '0;
         pronto   <= 1'b0;
         n1       <= COD_APAGADO;
         n2       <= COD_APAGADO;
         n3       <= COD_APAGADO;
         n4       <= COD_APAGADO;
         n5       <= COD_APAGADO;
      end else begin
         pronto <= 1'b0;

         if (captura) begin
            desloc <= valor_captura;
            bcd    <= '0;
            ovf    <= (valor_captura > LIMITE);
            cont   <= '0;
         end else if (estado == CONVERTE) begin
            bcd    <= conc_desl[BCD_W+LARGURA-1:LARGURA];
            desloc <= conc_desl[LARGURA-1:0];
            cont   <= cont + 1'b1;
         end

         if (estado == CONVERTE && controleOUT) begin
            pendente <= 1'b1;
            espera   <= entrada;
         end else if (estado == CONCLUI) begin
            pendente <= 1'b0;
         end

         if (estado == CONCLUI) begin
            pronto <= 1'b1;
            if (ovf) begin
               n1 <= COD_ERRO;
               n2 <= COD_ERRO;
               n3 <= COD_ERRO;
               n4 <= COD_ERRO;
               n5 <= COD_ERRO;
            end else begin
               n1 <= bcd[3:0];
               n2 <= bcd[7:4];
               n3 <= bcd[11:8];
               n4 <= bcd[15:12];
               n5 <= bcd[19:16];
            end
         end
      end
   end

endmodule

// File: tb/tb_conversor_bcd_saida.sv
module tb_conversor_bcd_saida;

   logic        clock = 1'b0;
   logic        reset;
   logic [31:0] entrada;
   logic        controleOUT;
   logic [3:0]  n1, n2, n3, n4, n5;
   logic        ocupado, pronto;

   int n_checks = 0;
   int n_fail   = 0;

   conversor_bcd_saida dut (
      .clock       (clock),
      .reset       (reset),
      .entrada     (entrada),
      .controleOUT (controleOUT),
      .n1          (n1),
      .n2          (n2),
      .n3          (n3),
      .n4          (n4),
      .n5          (n5),
      .ocupado     (ocupado),
      .pronto      (pronto)
   );

   always #5 clock = ~clock;

   logic [19:0] dig;
   assign dig = {n5, n4, n3, n2, n1};

   typedef struct {
      logic [31:0] valor;
      logic [19:0] esperado;
   } vetor_t;

   vetor_t tabela[12];

   // Reference: decimal digits of the value, or all "E" above 99999.
   function automatic logic [19:0] modelo(input logic [31:0] v);
      logic [19:0] r;
      longint      x;
      r = '0;
      if (v > 32'd99999) return 20'hEEEEE;
      x = longint'(v);
      for (int i = 0; i < 5; i++) begin
         r[4*i +: 4] = 4'(x % 10);
         x = x / 10;
      end
      return r;
   endfunction

   task automatic verifica(input string nome, input logic [31:0] obtido,
                           input logic [31:0] esperado);
      n_checks++;
      if (obtido !== esperado) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nome, obtido, esperado);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Pulse the strobe for one cycle and wait for pronto. lat counts edges
   // starting with the capturing edge as 1.
   task automatic converter(input logic [31:0] v, output int lat, output int ocup);
      entrada     = v;
      controleOUT = 1'b1;
      tick();
      controleOUT = 1'b0;
      lat  = 1;
      ocup = ocupado ? 1 : 0;
      while (!pronto && lat < 60) begin
         tick();
         lat++;
         if (ocupado) ocup++;
      end
   endtask

   int          pulsos;
   logic [19:0] vistos[$];
   logic        viu7;

   task automatic passo();
      tick();
      if (pronto) begin
         pulsos++;
         vistos.push_back(dig);
      end
      if (dig === 20'h00007) viu7 = 1'b1;
   endtask

   initial begin
      int          lat, ocup;
      logic [31:0] v;

      tabela[0]  = '{32'd0,          20'h00000};
      tabela[1]  = '{32'd99999,      20'h99999};
      tabela[2]  = '{32'd100000,     20'hEEEEE};
      tabela[3]  = '{32'd0,          20'h00000};
      tabela[4]  = '{32'hFFFFFFFF,   20'hEEEEE};
      tabela[5]  = '{32'd1,          20'h00001};
      tabela[6]  = '{32'd10,         20'h00010};
      tabela[7]  = '{32'd99,         20'h00099};
      tabela[8]  = '{32'd100,        20'h00100};
      tabela[9]  = '{32'd54321,      20'h54321};
      tabela[10] = '{32'd90909,      20'h90909};
      tabela[11] = '{32'h80000000,   20'hEEEEE};

      reset       = 1'b1;
      entrada     = '0;
      controleOUT = 1'b0;
      #12;
      verifica("reset_digitos", 32'(dig), 32'hFFFFF);
      verifica("reset_ocupado", 32'(ocupado), 0);
      verifica("reset_pronto", 32'(pronto), 0);
      reset = 1'b0;
      tick();

      converter(32'd12345, lat, ocup);
      verifica("latencia_12345", lat, 34);
      verifica("ocupado_ciclos", ocup, 32);
      verifica("digitos_12345", 32'(dig), 32'h12345);
      tick();
      verifica("pronto_um_ciclo", 32'(pronto), 0);

      for (int i = 0; i < 12; i++) begin
         converter(tabela[i].valor, lat, ocup);
         verifica("latencia_tabela", lat, 34);
         verifica("digitos_tabela", 32'(dig), 32'(tabela[i].esperado));
         verifica("sem_x", 32'($isunknown(dig)), 0);
      end

      // Pending requests: 7 is overwritten by 808 before it can be taken.
      pulsos = 0;
      viu7   = 1'b0;
      vistos.delete();
      entrada = 32'd42;  controleOUT = 1'b1; passo(); controleOUT = 1'b0;
      for (int i = 0; i < 3; i++) passo();
      entrada = 32'd7;   controleOUT = 1'b1; passo(); controleOUT = 1'b0;
      for (int i = 0; i < 5; i++) passo();
      entrada = 32'd808; controleOUT = 1'b1; passo(); controleOUT = 1'b0;
      entrada = 32'd7;
      for (int i = 0; i < 100; i++) passo();
      verifica("pendente_pulsos", pulsos, 2);
      verifica("pendente_primeiro", 32'(vistos.size() > 0 ? vistos[0] : 20'hxxxxx), 32'h00042);
      verifica("pendente_segundo", 32'(vistos.size() > 1 ? vistos[1] : 20'hxxxxx), 32'h00808);
      verifica("valor_7_nunca", 32'(viu7), 0);

      // Strobe held high: re-triggers on every completion.
      pulsos = 0;
      vistos.delete();
      entrada = 32'd5; controleOUT = 1'b1;
      for (int i = 0; i < 75; i++) passo();
      controleOUT = 1'b0;
      verifica("continuo_pulsos", pulsos, 2);
      pulsos = 0;
      for (int i = 0; i < 70; i++) passo();
      verifica("continuo_dreno", pulsos, 2);
      verifica("continuo_digitos", 32'(dig), 32'h00005);
      verifica("continuo_ocioso", 32'(ocupado), 0);

      for (int k = 0; k < 1000; k++) begin
         v = ($urandom_range(0, 1) == 1) ? $urandom : $urandom_range(0, 120000);
         converter(v, lat, ocup);
         verifica("latencia_aleatorio", lat, 34);
         verifica("digitos_aleatorio", 32'(dig), 32'(modelo(v)));
      end

      // Reset in mid-conversion after 10 shifts.
      entrada = 32'd12345; controleOUT = 1'b1; tick(); controleOUT = 1'b0;
      for (int i = 0; i < 10; i++) tick();
      #2 reset = 1'b1;
      #1;
      verifica("reset_meio_digitos", 32'(dig), 32'hFFFFF);
      verifica("reset_meio_ocupado", 32'(ocupado), 0);
      tick();
      #2 reset = 1'b0;
      pulsos = 0;
      for (int i = 0; i < 50; i++) passo();
      verifica("reset_meio_sem_pronto", pulsos, 0);
      verifica("reset_meio_apagado", 32'(dig), 32'hFFFFF);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
